qs_fifo_flex: RTL

//   Parametrised synchronous FIFO that succeeds the fixed 4x4 channel FIFO. Depth need not be a power of two.

---
 rtl/qs_fifo_flex.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/qs_fifo_flex.sv
// qs_fifo_flex: parametrised single-clock FIFO with fill count, programmable
// almost-full / almost-empty levels and sticky overflow / underflow flags.
// DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1.
//
// Ports
//   clk             rising-edge clock for all state
//   reset           synchronous reset, active low
//   push_i          push request; push_data_i written when accepted
//   pop_i           pop request
//   pop_data_o      read data: registered (FWFT=0) or head entry (FWFT=1)
//   empty_o         count == 0
//   full_o          count == DEPTH
//   almost_empty_o  count <= AE_LVL
//   almost_full_o   count >= AF_LVL
//   count_o         number of stored entries
//   clr_err_i       clears the sticky error flags
//   overflow_o      sticky: push seen while full and not accepted
//   underflow_o     sticky: pop seen while empty
module qs_fifo_flex #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 5,
    parameter int unsigned AF_LVL = 4,
    parameter int unsigned AE_LVL = 1,
    parameter bit          FWFT   = 1'b0,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_empty_o,
    output logic              almost_full_o,
    output logic [CNT_W-1:0]  count_o,
    input  logic              clr_err_i,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LVL);
    localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_LVL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic empty, full;
    logic pop_acc, push_acc;

    // Status is decoded only from registered count, so no request input
    // reaches a status output combinationally.
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // A push while full is accepted only when a pop frees the slot this cycle.
    assign pop_acc  = pop_i & ~empty;
    assign push_acc = push_i & (~full | pop_acc);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_acc) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clear first so that an error event in the same cycle wins.
        if (clr_err_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (push_i & full & ~pop_acc) begin
            overflow_d = 1'b1;
        end
        if (pop_i & empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; count/pointers define validity.
    always_ff @(posedge clk) begin
        if (reset && push_acc) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head entry straight from storage; a fresh write shows up only
            // after the edge that stores it (no bypass).
            assign pop_data_o = mem[rd_ptr_q];
        end else begin : g_reg
            logic [DATA_W-1:0] pop_data_q;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    pop_data_q <= '0;
                end else if (pop_acc) begin
                    pop_data_q <= mem[rd_ptr_q];
                end
            end

            assign pop_data_o = pop_data_q;
        end
    endgenerate

    assign empty_o        = empty;
    assign full_o         = full;
    assign almost_empty_o = (count_q <= AE_C);
    assign almost_full_o  = (count_q >= AF_C);
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule
